card_deploy_ctrl: RTL and testbench

//  Player-side consumer of the elixir bar. Decodes keyboard card/lane selection and checks the elixir level.

---
 rtl/clash_pkg.sv | 32 +++
 rtl/card_queue.sv | 34 +++
 rtl/card_deploy_ctrl.sv | 140 ++++++++++++++
 tb/tb_card_deploy_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clash_pkg.sv
// Shared card, state and keycode definitions for the card deployment path.
package clash_pkg;

   typedef enum logic [2:0] {
      KNIGHT, ARCHER, GIANT, MUSKETEER, MINION, GOBLIN, PEKKA, SKELETON
   } card_t;

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_SPEND, S_SPAWN, S_LOCKOUT
   } state_t;

   localparam logic [7:0] KEY_SLOT0  = 8'h1E;
   localparam logic [7:0] KEY_SLOT3  = 8'h21;
   localparam logic [7:0] KEY_LEFT   = 8'h04;
   localparam logic [7:0] KEY_RIGHT  = 8'h07;
   localparam logic [7:0] KEY_DEPLOY = 8'h28;
   localparam logic [7:0] KEY_CANCEL = 8'h29;

   function automatic logic [2:0] cost(input card_t c);
      case (c)
         KNIGHT:    cost = 3'd3;
         ARCHER:    cost = 3'd3;
         GIANT:     cost = 3'd5;
         MUSKETEER: cost = 3'd4;
         MINION:    cost = 3'd3;
         GOBLIN:    cost = 3'd2;
         PEKKA:     cost = 3'd7;
         default:   cost = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/card_queue.sv
// Four-entry rotation queue of cards waiting to enter the hand; always full.
module card_queue
   import clash_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rotate,
   input  logic [2:0] push_card,
   output logic [2:0] head_card
);

   card_t      entries [4];
   logic [1:0] head;
   logic [1:0] tail;

   // The queue never drains, so the pushed card lands in the slot just popped.
   always_ff @(posedge clk) begin
      if (reset) begin
         entries[0] <= MINION;
         entries[1] <= GOBLIN;
         entries[2] <= PEKKA;
         entries[3] <= SKELETON;
         head       <= '0;
         tail       <= '0;
      end else if (rotate) begin
         entries[tail] <= card_t'(push_card);
         head          <= head + 2'd1;
         tail          <= tail + 2'd1;
      end
   end

   assign head_card = entries[head];

endmodule

// File: rtl/card_deploy_ctrl.sv
// Keyboard-driven card deploy controller: arms a hand slot, spends elixir,
// hands a spawn request to the troop manager, then rotates the hand.
module card_deploy_ctrl
   import clash_pkg::*;
#(
   parameter int unsigned SPEND_SCALE = 3,
   parameter int unsigned LOCKOUT_CYC = 64,
   parameter int unsigned N_HAND      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_active,
   input  logic [7:0] keycode,
   input  logic [4:0] elixir_level,
   output logic [4:0] spend_units,
   output logic       spawn_valid,
   input  logic       spawn_ready,
   output logic [2:0] spawn_card,
   output logic       spawn_lane,
   output logic [2:0] hand_card [N_HAND],
   output logic       sel_valid,
   output logic [1:0] sel_slot,
   output logic       no_elixir,
   output logic       busy
);

   localparam int unsigned CW = $clog2(LOCKOUT_CYC + 1);

   state_t        state, state_n;
   card_t         hand [N_HAND];
   logic [7:0]    keycode_q;
   logic [1:0]    slot, slot_n;
   logic          lane, lane_n;
   card_t         spawn_card_r;
   logic          spawn_lane_r;
   logic [CW-1:0] cnt;
   logic          no_elixir_r;
   logic          refuse, rotate;
   logic [2:0]    q_head;

   logic       rst;
   logic       key_evt, is_slot;
   logic [1:0] key_slot;
   card_t      cur_card;
   logic [2:0] cur_cost;

   assign rst      = reset | ~game_active;
   assign key_evt  = (keycode != 8'h00) && (keycode != keycode_q);
   assign is_slot  = key_evt && (keycode >= KEY_SLOT0) && (keycode <= KEY_SLOT3);
   // 0x1E..0x21 have low bits 2,3,0,1; adding 2 maps them onto slots 0..3.
   assign key_slot = keycode[1:0] + 2'd2;
   assign cur_card = hand[slot];
   assign cur_cost = cost(cur_card);

   card_queue u_queue (
      .clk       (clk),
      .reset     (rst),
      .rotate    (rotate),
      .push_card (cur_card),
      .head_card (q_head)
   );

   always_comb begin
      state_n = state;
      slot_n  = slot;
      lane_n  = lane;
      refuse  = 1'b0;
      rotate  = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_slot) begin
               state_n = S_ARMED;
               slot_n  = key_slot;
               lane_n  = 1'b0;
            end
         end
         S_ARMED: begin
            if (is_slot) slot_n = key_slot;
            else if (key_evt && keycode == KEY_LEFT)   lane_n  = 1'b0;
            else if (key_evt && keycode == KEY_RIGHT)  lane_n  = 1'b1;
            else if (key_evt && keycode == KEY_CANCEL) state_n = S_IDLE;
            else if (key_evt && keycode == KEY_DEPLOY) begin
               if (elixir_level >= {2'b00, cur_cost}) state_n = S_SPEND;
               else                                   refuse  = 1'b1;
            end
         end
         S_SPEND: state_n = S_SPAWN;
         S_SPAWN: begin
            if (spawn_ready) begin
               rotate  = 1'b1;
               state_n = S_LOCKOUT;
            end
         end
         // Leave as the counter reaches zero so busy spans LOCKOUT_CYC cycles from SPEND.
         S_LOCKOUT: if (cnt <= CW'(1)) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      keycode_q <= keycode;
      if (rst) begin
         state        <= S_IDLE;
         slot         <= '0;
         lane         <= 1'b0;
         spawn_card_r <= KNIGHT;
         spawn_lane_r <= 1'b0;
         cnt          <= '0;
         no_elixir_r  <= 1'b0;
         for (int unsigned i = 0; i < N_HAND; i++) hand[i] <= card_t'(3'(i));
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         lane        <= lane_n;
         no_elixir_r <= refuse;
         if (state == S_SPEND) begin
            spawn_card_r <= cur_card;
            spawn_lane_r <= lane;
            cnt          <= CW'(LOCKOUT_CYC - 1);
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (rotate) hand[slot] <= card_t'(q_head);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_HAND; i++) hand_card[i] = hand[i];
   end

   assign spend_units = (state == S_SPEND) ? 5'({2'b00, cur_cost} * 5'(SPEND_SCALE)) : '0;
   assign spawn_valid = (state == S_SPAWN);
   assign spawn_card  = spawn_card_r;
   assign spawn_lane  = spawn_lane_r;
   assign sel_valid   = (state != S_IDLE);
   assign sel_slot    = slot;
   assign no_elixir   = no_elixir_r;
   assign busy        = (state == S_SPEND) || (state == S_SPAWN) || (state == S_LOCKOUT);

endmodule

// File: tb/tb_card_deploy_ctrl.sv
// Bench for card_deploy_ctrl: directed scenarios plus random deploys checked
// against a transaction-level hand/queue model.
module tb_card_deploy_ctrl;

   logic       clk = 1'b0;
   logic       reset, game_active, spawn_ready;
   logic [7:0] keycode;
   logic [4:0] elixir_level;
   logic [4:0] spend_units;
   logic       spawn_valid, spawn_lane, sel_valid, no_elixir, busy;
   logic [2:0] spawn_card;
   logic [1:0] sel_slot;
   logic [2:0] hand_card [4];

   int n_tests = 0;
   int n_fail  = 0;

   int cost_tab [8] = '{3, 3, 5, 4, 3, 2, 7, 1};
   int m_hand [4];
   int m_q [$];

   card_deploy_ctrl #(.SPEND_SCALE(3), .LOCKOUT_CYC(64), .N_HAND(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .game_active  (game_active),
      .keycode      (keycode),
      .elixir_level (elixir_level),
      .spend_units  (spend_units),
      .spawn_valid  (spawn_valid),
      .spawn_ready  (spawn_ready),
      .spawn_card   (spawn_card),
      .spawn_lane   (spawn_lane),
      .hand_card    (hand_card),
      .sel_valid    (sel_valid),
      .sel_slot     (sel_slot),
      .no_elixir    (no_elixir),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_hand = '{0, 1, 2, 3};
      m_q    = '{4, 5, 6, 7};
   endtask

   task automatic check_hand(input string tag);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_hand%0d", tag, i), hand_card[i], m_hand[i]);
   endtask

   task automatic press(input logic [7:0] k);
      keycode = k;
      tick();
      keycode = 8'h00;
      tick();
   endtask

   // lk: 0 = no lane key, 1 = 'A', 2 = 'D'; d = cycles spawn_valid waits before ready
   task automatic do_deploy(input int s, input int lk, input int elix, input int d, input bit hold);
      int c, exp_lane, n, spends, spawns, exp_busy, extra_spend, extra_spawn, played;
      elixir_level = 5'(elix);
      press(8'(8'h1E + s));
      exp_lane = 0;
      if (lk == 1) press(8'h04);
      else if (lk == 2) begin
         press(8'h07);
         exp_lane = 1;
      end
      chk("armed_sel_valid", sel_valid, 1);
      chk("armed_sel_slot", sel_slot, s);
      c = cost_tab[m_hand[s]];
      keycode = 8'h28;
      tick();
      if (!hold) keycode = 8'h00;
      if (elix < c) begin
         chk("refuse_no_elixir", no_elixir, 1);
         chk("refuse_spend", spend_units, 0);
         chk("refuse_busy", busy, 0);
         chk("refuse_sel_slot", sel_slot, s);
         keycode = 8'h00;
         tick();
         chk("refuse_pulse_end", no_elixir, 0);
         chk("refuse_still_armed", sel_valid, 1);
         press(8'h29);
         chk("cancel_sel_valid", sel_valid, 0);
         check_hand("refuse");
         return;
      end
      exp_busy = (d + 3 > 64) ? d + 3 : 64;
      n = 0; spends = 0; spawns = 0;
      while (busy && n < 400) begin
         if (n == 0) chk("spend_first_cycle", spend_units, c * 3);
         if (spend_units != 0) spends++;
         if (spawn_valid) begin
            spawns++;
            chk("spawn_card", spawn_card, m_hand[s]);
            chk("spawn_lane", spawn_lane, exp_lane);
         end
         spawn_ready = (n == d + 1);
         n++;
         tick();
      end
      spawn_ready = 1'b0;
      chk("busy_cycles", n, exp_busy);
      chk("spend_count", spends, 1);
      chk("spawn_cycles", spawns, d + 1);
      chk("idle_sel_valid", sel_valid, 0);
      played    = m_hand[s];
      m_hand[s] = m_q.pop_front();
      m_q.push_back(played);
      check_hand("rotate");
      if (hold) begin
         extra_spend = 0; extra_spawn = 0;
         for (int i = n; i < 200; i++) begin
            if (spend_units != 0) extra_spend++;
            if (spawn_valid) extra_spawn++;
            tick();
         end
         chk("hold_extra_spend", extra_spend, 0);
         chk("hold_extra_spawn", extra_spawn, 0);
         keycode = 8'h00;
         tick();
      end
   endtask

   initial begin
      int s, lk, elix, d;
      reset = 1'b1; game_active = 1'b1; keycode = 8'h00;
      elixir_level = 5'd0; spawn_ready = 1'b0;
      model_reset();
      tick(); tick();
      reset = 1'b0;
      tick();
      check_hand("reset");
      chk("reset_spend", spend_units, 0);
      chk("reset_spawn_valid", spawn_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_sel_valid", sel_valid, 0);
      chk("reset_no_elixir", no_elixir, 0);

      // Knight to the right lane, ready three cycles after the spend
      do_deploy(0, 2, 5, 2, 1'b0);
      chk("t2_hand0", hand_card[0], 4);
      // Giant with only 4 elixir is refused
      do_deploy(2, 0, 4, 0, 1'b0);
      // Deploy key held through the whole sequence
      do_deploy(1, 1, 10, 1, 1'b1);

      // Game stops mid-spawn
      elixir_level = 5'd10;
      press(8'h21);
      keycode = 8'h28;
      tick();
      keycode = 8'h00;
      chk("abort_spend", spend_units, 3 * cost_tab[m_hand[3]]);
      tick();
      chk("abort_spawn_before", spawn_valid, 1);
      game_active = 1'b0;
      tick();
      model_reset();
      chk("abort_spawn_valid", spawn_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_sel_valid", sel_valid, 0);
      check_hand("abort");
      game_active = 1'b1;
      tick();

      // Repeated slot-0 deploys wrap the queue
      for (int i = 0; i < 6; i++) begin
         do_deploy(0, 0, 10, 0, 1'b0);
         chk($sformatf("wrap_hand0_%0d", i), hand_card[0], (i < 4) ? 4 + i : (i == 4 ? 0 : 4));
      end

      for (int i = 0; i < 12; i++) begin
         s    = $urandom_range(0, 3);
         lk   = $urandom_range(0, 2);
         elix = $urandom_range(0, 10);
         d    = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 4);
         do_deploy(s, lk, elix, d, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

endmodule
